alu_top: RTL and testbench
==========================

// Module: alu_top
// PURPOSE
//   Registered 32-bit integer ALU: operands a, b and a 5-bit opcode in, one result word out.
//   Single clock domain. Result and flags are registered, with 1-cycle latency.
//   Sits as the execute-stage datapath leaf of the lab CPU. It also serves as a standalone board-level demo.
// PARAMETERS
//   WIDTH   32   operand/result width in bits (>=8); shift amount uses b[$clog2(WIDTH)-1:0]
// PORTS
//   clk     in   1      rising-edge clock (single clock domain)
//   rst_n   in   1      synchronous active-low reset, sampled on rising clk
//   a       in   WIDTH  operand A
//   b       in   WIDTH  operand B
//   op      in   5      opcode (see BEHAVIOUR)
//   out     out  WIDTH  registered result
//   zero    out  1      registered: result == 0
//   cout    out  1      registered: carry-out of ADD / NOT-borrow of SUB; 0 for other ops
//   ovf     out  1      registered: signed overflow of ADD/SUB; 0 for other ops
// BEHAVIOUR
//   - Reset: on a clk edge with rst_n=0, out=0, zero=1, cout=0, ovf=0. Reset overrides any op.
//   - Each clk edge with rst_n=1 registers f(a,b,op). Latency is exactly 1 cycle.
//     No handshake; a new op is accepted every cycle.
//   - Opcodes; all arithmetic is modulo 2^WIDTH:
//       00 ADD  a+b           01 SUB  a-b          02 AND  a&b          03 OR   a|b
//       04 XOR  a^b           05 NOR  ~(a|b)       06 SLT  signed a<b ? 1 : 0
//       07 SLL  a<<sh         08 SRL  a>>sh        09 SRA  a>>>sh (sign-fill)
//       0A SLTU unsigned a<b ? 1 : 0               0B MUL  (a*b)[WIDTH-1:0], see CONFIGURATION
//       0C..1F reserved -> out=0, cout=0, ovf=0, zero=1
//   - sh = b[$clog2(WIDTH)-1:0]; the upper bits of b are ignored for shifts.
//   - ADD: cout = carry out of bit WIDTH-1.
//     ovf = operand signs equal and result sign differs.
//   - SUB: computed as a+~b+1. cout = carry out (1 = no borrow).
//     ovf = operand signs differ and result sign != sign of a.
//   - SLT/SLTU results are 1 or 0 zero-extended to WIDTH; cout=ovf=0.
//   - zero always reflects the registered out value, including for reserved ops.
//   - Boundaries:
//       ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
//       SUB 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
//       ADD 0xFFFFFFFF+1 -> 0, cout=1, zero=1.
//       SRA 0x80000000 by 31 -> 0xFFFFFFFF.
//   - Inputs changing between edges have no effect until the next edge. No internal state beyond the output registers.
// CONFIGURATION
//   - Macro ALU_TOP_MUL_EN:
//       defined     -> op 0B returns the low WIDTH bits of the unsigned product, with cout=ovf=0.
//       not defined -> op 0B is treated as reserved (out=0, zero=1) and no multiplier is synthesised.
// STRUCTURE
//   - Package alu_top_pkg: localparam opcode constants OP_ADD..OP_MUL (5-bit) and OP_W=5.
//   - One sub-module, alu_top_addsub: a shared WIDTH-bit adder with a sub input.
//     It produces sum, cout and ovf and is used by ADD, SUB, SLT and SLTU.
//   - Top level: combinational result mux, then the output/flag register with synchronous reset.
// TESTING
//   - Reset: hold rst_n=0 for 2 cycles with a=5, b=2, op=00 -> out=0, zero=1, cout=0, ovf=0.
//   - a=5, b=2, sweep op 00..06 one per cycle. Each result must appear one cycle after its op:
//       00 -> 7        01 -> 3        02 -> 0 (zero=1)     03 -> 7
//       04 -> 7        05 -> 0xFFFFFFF8                    06 -> 0
//   - Flags:
//       ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1, cout=0.
//       ADD 0xFFFFFFFF+1 -> 0, cout=1, zero=1.
//       SUB 5-5 -> 0, cout=1, zero=1.
//   - Shifts/compares (a=0x80000000, b=31):
//       SLL -> 0          SRL -> 1          SRA -> 0xFFFFFFFF
//       SLT -> 1          SLTU -> 0
//   - Reserved op 0x1F with a=5, b=2 -> out=0, zero=1.
//     op 0B with a=3, b=4 -> 12 if ALU_TOP_MUL_EN is defined, else 0.
//   - Mid-stream reset: drop rst_n for 1 cycle during an ADD sweep.
//     Outputs go to reset values on that edge, and normal results resume on the next edge.

Source files
------------

// File: rtl/alu_top_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_top_pkg : opcode encodings shared by the ALU top level and its bench    |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_top_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'h00;
    localparam logic [OP_W-1:0] OP_SUB  = 5'h01;
    localparam logic [OP_W-1:0] OP_AND  = 5'h02;
    localparam logic [OP_W-1:0] OP_OR   = 5'h03;
    localparam logic [OP_W-1:0] OP_XOR  = 5'h04;
    localparam logic [OP_W-1:0] OP_NOR  = 5'h05;
    localparam logic [OP_W-1:0] OP_SLT  = 5'h06;
    localparam logic [OP_W-1:0] OP_SLL  = 5'h07;
    localparam logic [OP_W-1:0] OP_SRL  = 5'h08;
    localparam logic [OP_W-1:0] OP_SRA  = 5'h09;
    localparam logic [OP_W-1:0] OP_SLTU = 5'h0A;
    localparam logic [OP_W-1:0] OP_MUL  = 5'h0B;

endpackage

`default_nettype wire

// File: rtl/alu_top_addsub.sv
// +----------------------------------------------------------------------------+
// | alu_top_addsub : shared WIDTH-bit adder/subtractor (a + b or a + ~b + 1)    |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_top_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff = i_sub ? ~i_b : i_b;

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

    // Overflow when the effective addends agree in sign but the sum does not.
    assign o_ovf = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/alu_top.sv
// +----------------------------------------------------------------------------+
// | alu_top : registered integer ALU, 1-cycle latency, flags zero/cout/ovf.     |
// |           Define ALU_TOP_MUL_EN to enable op 0B (low-half multiply).        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_top
    import alu_top_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             cout,
    output logic             ovf
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]  w_sh;
    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_as_cout;
    logic             w_as_ovf;
    logic [WIDTH-1:0] w_result;
    logic             w_cout;
    logic             w_ovf;

    assign w_sh  = b[SH_W-1:0];
    assign w_sub = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);

    alu_top_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a    (a),
        .i_b    (b),
        .i_sub  (w_sub),
        .o_sum  (w_sum),
        .o_cout (w_as_cout),
        .o_ovf  (w_as_ovf)
    );

    always_comb begin
        w_result = '0;
        w_cout   = 1'b0;
        w_ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                w_result = w_sum;
                w_cout   = w_as_cout;
                w_ovf    = w_as_ovf;
            end
            OP_SUB: begin
                w_result = w_sum;
                w_cout   = w_as_cout;
                w_ovf    = w_as_ovf;
            end
            OP_AND:  w_result = a & b;
            OP_OR:   w_result = a | b;
            OP_XOR:  w_result = a ^ b;
            OP_NOR:  w_result = ~(a | b);
            // Signed less-than: true sign of a-b is the sum sign corrected by overflow.
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_as_ovf};
            OP_SLL:  w_result = a << w_sh;
            OP_SRL:  w_result = a >> w_sh;
            OP_SRA:  w_result = $signed(a) >>> w_sh;
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, ~w_as_cout};
`ifdef ALU_TOP_MUL_EN
            OP_MUL:  w_result = a * b;
`else
            OP_MUL:  w_result = '0;
`endif
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out  <= '0;
            zero <= 1'b1;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            out  <= w_result;
            zero <= (w_result == '0);
            cout <= w_cout;
            ovf  <= w_ovf;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_top.sv
// +----------------------------------------------------------------------------+
// | tb_alu_top : self-checking bench for alu_top (directed + random vs model).  |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_top;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] out;
    logic        zero;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    alu_top #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .op    (op),
        .out   (out),
        .zero  (zero),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_out, input logic e_zero,
                           input logic e_cout, input logic e_ovf);
        chk($sformatf("%s.out", tag),  out,          e_out);
        chk($sformatf("%s.zero", tag), {31'b0, zero}, {31'b0, e_zero});
        chk($sformatf("%s.cout", tag), {31'b0, cout}, {31'b0, e_cout});
        chk($sformatf("%s.ovf", tag),  {31'b0, ovf},  {31'b0, e_ovf});
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [31:0] ta, input logic [31:0] tb, input logic [4:0] top,
                                  output logic [31:0] r, output logic c, output logic v);
        longint unsigned ua;
        longint unsigned ub;
        longint          sa;
        longint          sb;
        longint          s;
        ua = {32'b0, ta};
        ub = {32'b0, tb};
        sa = $signed(ta);
        sb = $signed(tb);
        r  = 32'h0;
        c  = 1'b0;
        v  = 1'b0;
        case (top)
            5'h00: begin
                r = ta + tb;
                c = (ua + ub) > 64'hFFFF_FFFF;
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'h01: begin
                r = ta - tb;
                c = (ua >= ub);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'h02: r = ta & tb;
            5'h03: r = ta | tb;
            5'h04: r = ta ^ tb;
            5'h05: r = ~(ta | tb);
            5'h06: r = (sa < sb) ? 32'd1 : 32'd0;
            5'h07: r = ta << tb[4:0];
            5'h08: r = ta >> tb[4:0];
            5'h09: r = 32'(sa >>> tb[4:0]);
            5'h0A: r = (ua < ub) ? 32'd1 : 32'd0;
`ifdef ALU_TOP_MUL_EN
            5'h0B: r = 32'(ua * ub);
`endif
            default: r = 32'h0;
        endcase
    endfunction

    task automatic cycle(input logic [31:0] ta, input logic [31:0] tb, input logic [4:0] top,
                         input logic trst_n);
        @(negedge clk);
        a     = ta;
        b     = tb;
        op    = top;
        rst_n = trst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic run_exp(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic [4:0] top, input logic [31:0] e_out, input logic e_zero,
                           input logic e_cout, input logic e_ovf);
        cycle(ta, tb, top, 1'b1);
        chk_all(tag, e_out, e_zero, e_cout, e_ovf);
    endtask

    task automatic run_model(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                             input logic [4:0] top);
        logic [31:0] r;
        logic        c;
        logic        v;
        model(ta, tb, top, r, c, v);
        cycle(ta, tb, top, 1'b1);
        chk_all(tag, r, (r == 32'h0), c, v);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        a     = 32'd5;
        b     = 32'd2;
        op    = 5'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 1'b1, 1'b0, 1'b0);

        run_exp("add5_2", 32'd5, 32'd2, 5'h00, 32'd7,         1'b0, 1'b0, 1'b0);
        run_exp("sub5_2", 32'd5, 32'd2, 5'h01, 32'd3,         1'b0, 1'b1, 1'b0);
        run_exp("and5_2", 32'd5, 32'd2, 5'h02, 32'd0,         1'b1, 1'b0, 1'b0);
        run_exp("or5_2",  32'd5, 32'd2, 5'h03, 32'd7,         1'b0, 1'b0, 1'b0);
        run_exp("xor5_2", 32'd5, 32'd2, 5'h04, 32'd7,         1'b0, 1'b0, 1'b0);
        run_exp("nor5_2", 32'd5, 32'd2, 5'h05, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0);
        run_exp("slt5_2", 32'd5, 32'd2, 5'h06, 32'd0,         1'b1, 1'b0, 1'b0);

        run_exp("add_ovf",   32'h7FFF_FFFF, 32'd1, 5'h00, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        run_exp("add_carry", 32'hFFFF_FFFF, 32'd1, 5'h00, 32'h0,         1'b1, 1'b1, 1'b0);
        run_exp("sub_eq",    32'd5,         32'd5, 5'h01, 32'h0,         1'b1, 1'b1, 1'b0);
        run_exp("sub_ovf",   32'h8000_0000, 32'd1, 5'h01, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);

        run_exp("sll31",  32'h8000_0000, 32'd31, 5'h07, 32'h0,         1'b1, 1'b0, 1'b0);
        run_exp("srl31",  32'h8000_0000, 32'd31, 5'h08, 32'h1,         1'b0, 1'b0, 1'b0);
        run_exp("sra31",  32'h8000_0000, 32'd31, 5'h09, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_exp("slt_neg",  32'h8000_0000, 32'd31, 5'h06, 32'h1,       1'b0, 1'b0, 1'b0);
        run_exp("sltu_big", 32'h8000_0000, 32'd31, 5'h0A, 32'h0,       1'b1, 1'b0, 1'b0);
        run_exp("sll_hib",  32'h0000_0001, 32'hFFFF_FFE4, 5'h07, 32'h10, 1'b0, 1'b0, 1'b0);

        run_exp("rsv1f", 32'd5, 32'd2, 5'h1F, 32'h0, 1'b1, 1'b0, 1'b0);
`ifdef ALU_TOP_MUL_EN
        run_exp("mul3_4", 32'd3, 32'd4, 5'h0B, 32'd12, 1'b0, 1'b0, 1'b0);
`else
        run_exp("mul3_4", 32'd3, 32'd4, 5'h0B, 32'd0,  1'b1, 1'b0, 1'b0);
`endif

        // Reset pulse in the middle of an ADD sweep.
        run_exp("sweep1", 32'd1, 32'd10, 5'h00, 32'd11, 1'b0, 1'b0, 1'b0);
        cycle(32'd2, 32'd10, 5'h00, 1'b0);
        chk_all("midrst", 32'h0, 1'b1, 1'b0, 1'b0);
        run_exp("sweep3", 32'd3, 32'd10, 5'h00, 32'd13, 1'b0, 1'b0, 1'b0);
        run_exp("sweep4", 32'd4, 32'd10, 5'h00, 32'd14, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [4:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            ra  = pick_operand();
            rb  = pick_operand();
            rop = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(12, 31))
                                              : 5'($urandom_range(0, 11));
            run_model($sformatf("rnd%0d_op%0h", i, rop), ra, rb, rop);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
